// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with a 32-byte register window.
// Optional prescaler is built when MMIO_TIMER_PRESCALER_EN is defined.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Write_i,
  input  logic        Mem_Read_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Hit_o,
  output logic        Irq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic        exp_q, exp_d;
  logic        irq_q, irq_d;
`ifdef MMIO_TIMER_PRESCALER_EN
  logic [15:0] presc_q, presc_d;
  logic [15:0] psc_cnt_q, psc_cnt_d;
  logic        wr_presc;
`endif

  logic        hit;
  logic [2:0]  idx;
  logic        wr_en;
  logic        wr_ctrl, wr_load, wr_stat;
  logic        tick, expire;
  logic [31:0] reg_rdata;
  logic        unused_addr_lsb;

  assign hit             = (Address_i[31:5] == BASE_ADDR[31:5]);
  assign idx             = Address_i[4:2];
  assign unused_addr_lsb = ^Address_i[1:0];
  assign wr_en           = hit & Mem_Write_i;
  assign wr_ctrl         = wr_en & (idx == 3'd0);
  assign wr_load         = wr_en & (idx == 3'd1);
  assign wr_stat         = wr_en & (idx == 3'd3);
`ifdef MMIO_TIMER_PRESCALER_EN
  assign wr_presc        = wr_en & (idx == 3'd4);
`endif

  assign Hit_o = hit;
  assign Irq_o = irq_q;

  always_comb begin
    reg_rdata = '0;
    case (idx)
      3'd0: reg_rdata[2:0] = ctrl_q;
      3'd1: reg_rdata      = load_q;
      3'd2: reg_rdata      = count_q;
      3'd3: reg_rdata[0]   = exp_q;
`ifdef MMIO_TIMER_PRESCALER_EN
      3'd4: reg_rdata[15:0] = presc_q;
`endif
      default: reg_rdata = '0;
    endcase
    Read_Data_o = (hit && Mem_Read_i) ? reg_rdata : '0;
  end

  // Counting runs first; a CTRL write then overrides state/COUNT, and expiry
  // is applied to EXP last so it beats a same-cycle W1C.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    tick    = 1'b0;
    expire  = 1'b0;
`ifdef MMIO_TIMER_PRESCALER_EN
    presc_d   = presc_q;
    psc_cnt_d = psc_cnt_q;
    if (wr_presc) presc_d = Write_Data_i[15:0];
`endif
    if (wr_load) load_d = Write_Data_i;
    if (wr_ctrl) ctrl_d = Write_Data_i[2:0];

    case (state_q)
      RUN: begin
`ifdef MMIO_TIMER_PRESCALER_EN
        tick      = (psc_cnt_q >= presc_q);
        psc_cnt_d = tick ? '0 : psc_cnt_q + 16'd1;
`else
        tick      = 1'b1;
`endif
        if (tick) begin
          if (count_q != '0) begin
            count_d = count_q - 32'd1;
          end else begin
            expire = 1'b1;
            if (ctrl_q[1]) begin
              count_d = load_q;
            end else begin
              ctrl_d[0] = 1'b0;
              state_d   = DONE;
            end
          end
        end
      end
      default: ;
    endcase

    if (wr_ctrl) begin
      if (!Write_Data_i[0]) begin
        state_d = IDLE;
        count_d = count_q;
      end else if (state_q != RUN) begin
        state_d = RUN;
        count_d = load_q;
`ifdef MMIO_TIMER_PRESCALER_EN
        psc_cnt_d = '0;
`endif
      end
    end

    if (wr_stat && Write_Data_i[0]) exp_d = 1'b0;
    if (expire) exp_d = 1'b1;

    irq_d = exp_d & ctrl_d[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      load_q    <= '0;
      count_q   <= '0;
      exp_q     <= 1'b0;
      irq_q     <= 1'b0;
`ifdef MMIO_TIMER_PRESCALER_EN
      presc_q   <= '0;
      psc_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      count_q   <= count_d;
      exp_q     <= exp_d;
      irq_q     <= irq_d;
`ifdef MMIO_TIMER_PRESCALER_EN
      presc_q   <= presc_d;
      psc_cnt_q <= psc_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed testbench for mmio_timer (table-driven plus corner-case sequences).
module tb_mmio_timer;

  localparam logic [31:0] BASE  = 32'h1001_0100;
  localparam logic [31:0] CTRL  = BASE + 32'h00;
  localparam logic [31:0] LOAD  = BASE + 32'h04;
  localparam logic [31:0] COUNT = BASE + 32'h08;
  localparam logic [31:0] STAT  = BASE + 32'h0C;
  localparam logic [31:0] PRESC = BASE + 32'h10;
`ifdef MMIO_TIMER_PRESCALER_EN
  localparam logic [31:0] PRESC_RB   = 32'h0000_ABCD;
  localparam logic [31:0] PRESC2_RB  = 32'd2;
  localparam logic [31:0] EXP_SEEN_K = 32'd7;
`else
  localparam logic [31:0] PRESC_RB   = 32'd0;
  localparam logic [31:0] PRESC2_RB  = 32'd0;
  localparam logic [31:0] EXP_SEEN_K = 32'd3;
`endif

  logic        clk;
  logic        reset;
  logic        mw, mr;
  logic [31:0] addr, wd;
  logic [31:0] rd;
  logic        hit, irq;

  int n_checks;
  int n_fail;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .Mem_Write_i  (mw),
    .Mem_Read_i   (mr),
    .Address_i    (addr),
    .Write_Data_i (wd),
    .Read_Data_o  (rd),
    .Hit_o        (hit),
    .Irq_o        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] w, input logic [31:0] e,
                     input logic h, input logic i);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.wdata = w;
    v.exp_rd = e; v.exp_hit = h; v.exp_irq = i;
    vecs.push_back(v);
  endtask

  // One bus cycle: drive after the edge, sample at negedge, return after next edge.
  task automatic cycle(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] w, output logic [31:0] r,
                       output logic h, output logic q);
    mw = we; mr = re; addr = a; wd = w;
    @(negedge clk);
    r = rd; h = hit; q = irq;
    @(posedge clk);
    #1;
    mw = 1'b0; mr = 1'b0; addr = '0; wd = '0;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] r;
    logic h, q;
    cycle(1'b1, 1'b0, a, w, r, h, q);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic h, q;
    cycle(1'b0, 1'b1, a, '0, r, h, q);
    check32(name, r, exp);
  endtask

  task automatic irq_chk(input string name, input logic exp);
    logic [31:0] r;
    logic h, q;
    cycle(1'b0, 1'b0, '0, '0, r, h, q);
    check1(name, q, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mw = 1'b0; mr = 1'b0; addr = '0; wd = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        h, q;
    logic [31:0] found;

    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; mw = 1'b0; mr = 1'b0; addr = '0; wd = '0;
    do_reset();

    // Reset state, one-shot count, decode and register-map vectors.
    add(0, 1, CTRL,  0, 0, 1, 0);
    add(0, 1, LOAD,  0, 0, 1, 0);
    add(0, 1, COUNT, 0, 0, 1, 0);
    add(0, 1, STAT,  0, 0, 1, 0);
    add(0, 1, PRESC, 0, 0, 1, 0);
    add(1, 0, LOAD,  3, 0, 1, 0);
    add(1, 0, CTRL,  1, 0, 1, 0);
    add(0, 1, COUNT, 0, 3, 1, 0);
    add(0, 1, COUNT, 0, 2, 1, 0);
    add(0, 1, COUNT, 0, 1, 1, 0);
    add(0, 1, COUNT, 0, 0, 1, 0);
    add(0, 1, STAT,  0, 1, 1, 0);
    add(0, 1, CTRL,  0, 0, 1, 0);
    add(0, 1, COUNT, 0, 0, 1, 0);
    add(0, 0, COUNT, 0, 0, 1, 0);
    add(0, 1, BASE + 32'h18, 0, 0, 1, 0);
    add(0, 1, 32'h1001_0200, 0, 0, 0, 0);
    add(0, 1, BASE + 32'h0D, 0, 1, 1, 0);
    add(1, 0, STAT,  1, 0, 1, 0);
    add(0, 1, STAT,  0, 0, 1, 0);
    add(1, 0, COUNT, 32'h55, 0, 1, 0);
    add(0, 1, COUNT, 0, 0, 1, 0);
    add(1, 0, BASE + 32'h1C, 32'hFFFF_FFFF, 0, 1, 0);
    add(0, 1, BASE + 32'h1C, 0, 0, 1, 0);
    add(1, 0, CTRL,  32'hFFFF_FFF6, 0, 1, 0);
    add(0, 1, CTRL,  0, 6, 1, 0);
    add(1, 0, CTRL,  0, 0, 1, 0);
    add(1, 0, PRESC, 32'h1234_ABCD, 0, 1, 0);
    add(0, 1, PRESC, 0, PRESC_RB, 1, 0);
    add(1, 0, PRESC, 0, 0, 1, 0);
    add(1, 0, 32'h1001_0000, 7, 0, 0, 0);
    add(0, 1, CTRL,  0, 0, 1, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, r, h, q);
      check32($sformatf("vec%0d rdata", i), r, vecs[i].exp_rd);
      check1($sformatf("vec%0d hit", i), h, vecs[i].exp_hit);
      check1($sformatf("vec%0d irq", i), q, vecs[i].exp_irq);
    end

    // Auto-reload with interrupt: expiries two ticks apart, W1C drops Irq.
    do_reset();
    wr(LOAD, 1);
    wr(CTRL, 7);
    cycle(0, 1, STAT, 0, r, h, q);
    check1("ar irq c1", q, 1'b0);
    check32("ar stat c1", r, 0);
    irq_chk("ar irq c2", 1'b0);
    cycle(1, 1, STAT, 1, r, h, q);
    check1("ar irq rise", q, 1'b1);
    check32("ar stat rise", r, 1);
    cycle(0, 1, STAT, 0, r, h, q);
    check1("ar irq after w1c", q, 1'b0);
    check32("ar stat after w1c", r, 0);
    cycle(0, 1, STAT, 0, r, h, q);
    check1("ar irq reassert", q, 1'b1);
    check32("ar stat reassert", r, 1);

    // W1C colliding with expiry: set wins.
    do_reset();
    wr(LOAD, 0);
    wr(CTRL, 3);
    wr(STAT, 1);
    cycle(1, 1, STAT, 1, r, h, q);
    check32("collide stat c2", r, 1);
    rd_chk("collide stat c3", STAT, 1);

    // CTRL EN=0 write colliding with expiry: IDLE, EXP set, COUNT frozen; EN=1 reloads.
    do_reset();
    wr(LOAD, 1);
    wr(CTRL, 3);
    irq_chk("stop irq c1", 1'b0);
    wr(CTRL, 2);
    rd_chk("stop stat", STAT, 1);
    rd_chk("stop ctrl", CTRL, 2);
    rd_chk("stop count a", COUNT, 0);
    rd_chk("stop count b", COUNT, 0);
    wr(CTRL, 1);
    rd_chk("restart count", COUNT, 1);

    // LOAD written during RUN applies only at the next reload.
    do_reset();
    wr(LOAD, 2);
    wr(CTRL, 3);
    wr(LOAD, 4);
    rd_chk("ldrun count c2", COUNT, 1);
    rd_chk("ldrun count c3", COUNT, 0);
    rd_chk("ldrun count reload", COUNT, 4);

    // Prescaler timing: first cycle in which EXP reads 1 after enable.
    do_reset();
    wr(PRESC, 2);
    wr(LOAD, 1);
    wr(CTRL, 1);
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle(0, 1, STAT, 0, r, h, q);
      if (found == 0 && r[0]) found = 32'(k);
    end
    check32("presc exp cycle", found, EXP_SEEN_K);
    rd_chk("presc readback", PRESC, PRESC2_RB);

    // Reset mid-count with a simultaneous write.
    do_reset();
    wr(LOAD, 0);
    wr(CTRL, 5);
    irq_chk("rst irq pre a", 1'b0);
    irq_chk("rst irq pre b", 1'b1);
    wr(LOAD, 5);
    wr(CTRL, 5);
    rd_chk("rst count5", COUNT, 5);
    wr(PRESC, 3);
    reset = 1'b1;
    cycle(1, 1, LOAD, 7, r, h, q);
    reset = 1'b0;
    check32("rst pre load", r, 5);
    check1("rst pre irq", q, 1'b1);
    cycle(0, 1, CTRL, 0, r, h, q);
    check32("rst ctrl", r, 0);
    check1("rst irq", q, 1'b0);
    rd_chk("rst load", LOAD, 0);
    rd_chk("rst count", COUNT, 0);
    rd_chk("rst stat", STAT, 0);
    rd_chk("rst presc", PRESC, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1001_0100: base of the 32-byte register window; bits [4:0] are zero.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 Mem_Write_i  input  1  store strobe from the core data bus.
REQ-005 Mem_Read_i  input  1  load strobe from the core data bus.
REQ-006 Address_i  input  32  byte address from the core ALU result.
REQ-007 Write_Data_i  input  32  store data, taken from rs2.
REQ-008 Read_Data_o  output  32  load data, combinational, valid in the same cycle.
REQ-009 Hit_o  output  1  combinational; high when Address_i is inside the window; selects this block over Data_Memory on loads.
REQ-010 Irq_o  output  1  registered level; equals STATUS.EXP AND CTRL.IE.

Function
REQ-011 Select: Address_i[31:5]==BASE_ADDR[31:5]; register index = Address_i[4:2]; Address_i[1:0] is ignored.
REQ-012 Register map:
- 0x00 CTRL, RW: bit0 EN, bit1 AR (auto-reload), bit2 IE; bits [31:3] read 0.
- 0x04 LOAD, RW, 32-bit.
- 0x08 COUNT, RO.
- 0x0C STATUS: bit0 EXP, write-1-to-clear.
- 0x10 PRESC, RW, 16-bit, see REQ-026.
- 0x14..0x1C: unmapped; reads return 0, writes are ignored.
REQ-013 Read_Data_o is 0 unless Hit_o and Mem_Read_i are both high.
REQ-014 Writes take effect at the clock edge while Hit_o and Mem_Write_i are high; a write to COUNT is ignored.
REQ-015 The FSM has three states: IDLE, RUN and DONE.
REQ-016 From IDLE or DONE, a CTRL write with EN=1 loads COUNT<=LOAD, clears the prescaler and enters RUN at the next edge.
REQ-017 In RUN, each tick with COUNT!=0 performs COUNT<=COUNT-1, so the period is LOAD+1 ticks.
REQ-018 In RUN, a tick with COUNT==0 sets EXP.
- If AR=1: COUNT<=LOAD and the FSM stays in RUN.
- If AR=0: EN is cleared, COUNT holds 0 and the FSM enters DONE.
REQ-019 A CTRL write with EN=0 in any state enters IDLE and freezes COUNT; a later EN=1 reloads COUNT from LOAD.
REQ-020 A LOAD write during RUN does not alter COUNT; the new value applies at the next reload.
REQ-021 Simultaneous expiry and a W1C write to EXP: set wins, EXP stays 1.
REQ-022 Simultaneous CTRL write with EN=0 and expiry: the write wins (IDLE); EXP is still set.
REQ-023 LOAD=0 with AR=1 expires on every tick.
REQ-024 A same-cycle read returns pre-edge register values.

Reset
REQ-025 On reset high at an edge:
- CTRL=0, LOAD=0, COUNT=0, STATUS=0, PRESC=0, prescaler counter=0.
- FSM=IDLE and Irq_o=0.
- Reset applies mid-count and overrides any same-cycle write.

Configuration
REQ-026 Macro MMIO_TIMER_PRESCALER_EN:
- Defined: a tick occurs when the prescaler counter reaches PRESC, after which the counter wraps to 0; PRESC=0 gives a tick every cycle.
- Undefined: every cycle in RUN is a tick, the PRESC register is absent and offset 0x10 reads 0.

Verification
REQ-027 One-shot: write LOAD=3, then CTRL=0x1, PRESC=0.
- Required: COUNT reads 3,2,1,0 on successive cycles.
- Required: EXP=1 on the 5th cycle after the write, FSM in DONE, CTRL reads 0.
REQ-028 Auto-reload with interrupt: LOAD=1, CTRL=0x7.
- Required: Irq_o rises after 2 ticks.
- Required: a W1C write of 0x1 to 0x0C drops Irq_o; it reasserts 2 ticks later.
REQ-029 Collision: a W1C of EXP in the same cycle as expiry (LOAD=0, CTRL=0x3) -> EXP reads 1.
REQ-030 Decode: read of BASE_ADDR+0x18 or 0x1001_0200 -> Read_Data_o=0; Hit_o is 1 and 0 respectively.
REQ-031 Prescaler, macro defined: PRESC=2, LOAD=1, CTRL=0x1 -> EXP sets 6 cycles after enable. Macro undefined: the same stimulus sets EXP after 2 cycles and PRESC reads 0.
REQ-032 Reset asserted while COUNT=5 in RUN -> all registers read 0 and Irq_o=0 on the next cycle.
